// File: rtl/lvds_tx.sv
// 2-bit strobed DDR serializer: pops 32-bit words from the TX FIFO, forces the
// I/Q sync fields and shifts each word out MSB-first as 16 strobed symbols.
module lvds_tx #(
    parameter int unsigned FRAME_GAP = 0,
    parameter int unsigned GAP_W     = 4
) (
    input  logic        i_rst_b,
    input  logic        i_ddr_clk,
    input  logic        i_tx_en,
    input  logic        i_fifo_empty,
    input  logic [31:0] i_fifo_data,
    output logic        o_fifo_read_clk,
    output logic        o_fifo_pop,
    output logic [1:0]  o_ddr_data,
    output logic        o_ddr_strobe,
    output logic        o_tx_busy,
    output logic [2:0]  o_debug_state
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        POP  = 3'b001,
        LOAD = 3'b010,
        SEND = 3'b011,
        GAP  = 3'b100
    } state_t;

    localparam bit              PREFETCH = (FRAME_GAP == 0);
    localparam bit              HAS_GAP  = (FRAME_GAP > 0);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(FRAME_GAP);

    state_t             state_q, state_d;
    logic [31:0]        sr_q, sr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               pop_q, pop_d;
    logic               pf_q, pf_d;
    logic [1:0]         data_q, data_d;
    logic               strobe_q, strobe_d;
    logic [31:0]        fmt_w;

    // I sync = 10 in [31:30], Q sync = 01 in [15:14], bit 0 cleared for the receiver's flag
    assign fmt_w = (i_fifo_data & 32'h3FFF_3FFE) | 32'h8000_4000;

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        pop_d    = 1'b0;
        pf_d     = pf_q;
        data_d   = data_q;
        strobe_d = strobe_q;
        case (state_q)
            IDLE: begin
                data_d   = '0;
                strobe_d = 1'b0;
                pf_d     = 1'b0;
                if (i_tx_en && !i_fifo_empty) begin
                    pop_d   = 1'b1;
                    state_d = POP;
                end
            end
            POP: state_d = LOAD;
            LOAD: begin
                data_d   = fmt_w[31:30];
                sr_d     = {fmt_w[29:0], 2'b00};
                strobe_d = 1'b1;
                cnt_d    = '0;
                state_d  = SEND;
            end
            SEND: begin
                if (cnt_q != 4'd15) begin
                    data_d = sr_q[31:30];
                    sr_d   = {sr_q[29:0], 2'b00};
                    cnt_d  = cnt_q + 4'd1;
                    // Prefetch so the next word lands in the last-symbol cycle
                    if (PREFETCH && cnt_q == 4'd13 && i_tx_en && !i_fifo_empty) begin
                        pop_d = 1'b1;
                        pf_d  = 1'b1;
                    end
                end else if (pf_q) begin
                    data_d = fmt_w[31:30];
                    sr_d   = {fmt_w[29:0], 2'b00};
                    cnt_d  = '0;
                    pf_d   = 1'b0;
                end else begin
                    strobe_d = 1'b0;
                    data_d   = '0;
                    if (HAS_GAP) begin
                        gap_d   = GAP_INIT;
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - 1'b1;
                if (gap_q <= 1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            pop_q    <= 1'b0;
            pf_q     <= 1'b0;
            data_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            pop_q    <= pop_d;
            pf_q     <= pf_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    assign o_fifo_read_clk = i_ddr_clk;
    assign o_fifo_pop      = pop_q;
    assign o_ddr_data      = data_q;
    assign o_ddr_strobe    = strobe_q;
    assign o_tx_busy       = (state_q != IDLE);
    assign o_debug_state   = state_q;

endmodule
